change_dispense_ctrl: RTL and testbench
=======================================

CHANGE_DISPENSE_CTRL -- requirements
Module: change_dispense_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- TIMEOUT_CYCLES, 1000, max cycles in REQ waiting for dispense_ack before fault.
- CNT_W, 5, width of note_cnt.

REQ-002 Ports SHALL be (name  direction  width  meaning):
- sys_clk  in  1  clock, rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; load change_amt and begin payout.
- change_amt  in  8  change to return, unsigned units (0..255).
- stock_empty  in  5  per-denomination empty flag; bit i refers to denom code i.
- dispense_ack  in  1  actuator acknowledge, four-phase.
- dispense_req  out  1  actuator request, registered.
- dispense_denom  out  3  denom code: 0=1, 1=5, 2=10, 3=20, 4=50; held stable while dispense_req=1.
- remaining  out  8  change still owed.
- note_cnt  out  CNT_W  notes dispensed this payout, saturating.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- fault  out  1  sticky error flag; cleared by next accepted start.

Function
REQ-010 States SHALL be IDLE, SELECT, REQ, RELEASE, DONE, FAULT.
REQ-011 IDLE + start SHALL:
- load remaining=change_amt;
- clear note_cnt and fault;
- go to SELECT next cycle.
REQ-012 start outside IDLE SHALL be ignored.
REQ-013 SELECT (one cycle) SHALL take one of three exits:
- remaining==0 -> DONE;
- otherwise pick the largest-value code whose value <= remaining and whose stock_empty bit is 0; register it on dispense_denom -> REQ;
- no eligible code -> FAULT.
REQ-014 dispense_req SHALL be 1 exactly while in REQ.
REQ-015 In REQ, the first cycle with dispense_ack=1 SHALL:
- subtract the selected value from remaining;
- increment note_cnt (saturating at all-ones);
- go to RELEASE (dispense_req=0 on the next cycle).
REQ-016 RELEASE SHALL wait until dispense_ack=0, then go to SELECT.
REQ-017 A cycle counter SHALL clear on REQ entry. If it reaches TIMEOUT_CYCLES without ack, go to FAULT. remaining SHALL be unchanged on timeout.
REQ-018 DONE SHALL assert done for one cycle, then go to IDLE. Minimum start-to-done latency with change_amt=0 is 3 cycles: SELECT, DONE, done visible.
REQ-019 FAULT SHALL:
- set fault=1;
- keep dispense_req=0;
- hold remaining;
- return to IDLE next cycle, with fault staying 1 in IDLE.
REQ-020 stock_empty SHALL be sampled only in SELECT; changes during REQ/RELEASE do not affect the note in flight.
REQ-021 Subtraction SHALL never underflow, guaranteed by the REQ-013 selection rule.
REQ-022 dispense_ack=1 while in IDLE, SELECT or DONE SHALL be ignored.

Reset
REQ-030 On sys_rst_n=0, asynchronously:
- state=IDLE;
- dispense_req=0, dispense_denom=0, remaining=0, note_cnt=0;
- busy=0, done=0, fault=0;
- timeout counter=0.
REQ-031 Reset mid-payout SHALL abandon the payout with no further request. The owed amount is not retained.

Structure
REQ-040 The shared package vm_pkg SHALL hold:
- denom codes and the code-to-value table (1, 5, 10, 20, 50);
- the state encoding (one-hot, 6 bits);
- the 8-bit money width constant.
REQ-041 The combinational largest-eligible-denomination picker SHALL be a sub-module named change_denom_pick. Inputs: remaining, stock_empty. Outputs: code, valid.
REQ-042 The block SHALL be driven by the vending state machine's CHANGE phase: start on entry, change_amt = input_money - need_money. It SHALL be instantiated alongside that machine.

Verification
REQ-050 change_amt=88, stock_empty=0, ack 2 cycles after each req:
- codes 4,3,2,1,0,0,0 (50, 20, 10, 5, 1, 1, 1);
- note_cnt=7, remaining=0, done pulse, fault=0.
REQ-051 change_amt=0:
- no dispense_req;
- done pulses 3 cycles after start;
- busy high for 2 cycles.
REQ-052 change_amt=30, stock_empty=5'b01000 (20 empty) -> codes 2,2,2, note_cnt=3, done.
REQ-053 change_amt=3, stock_empty=5'b00001 (1 empty):
- no request;
- fault=1, remaining=3;
- the next start with stock restored clears fault.
REQ-054 change_amt=10, ack held 0 -> fault after TIMEOUT_CYCLES in REQ, dispense_req=0, remaining=10.
REQ-055 Other directed checks:
- start while busy is ignored;
- ack held high across RELEASE: no second decrement until ack falls;
- sys_rst_n pulsed low mid-REQ: all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: money width, denomination codes and values,
// and the one-hot state encoding of the change dispenser.
package vm_pkg;

  localparam int MONEY_W    = 8;
  localparam int NUM_DENOMS = 5;
  localparam int DENOM_W    = 3;

  typedef enum logic [DENOM_W-1:0] {
    DENOM_1  = 3'd0,
    DENOM_5  = 3'd1,
    DENOM_10 = 3'd2,
    DENOM_20 = 3'd3,
    DENOM_50 = 3'd4
  } denom_e;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_SELECT  = 6'b000010,
    ST_REQ     = 6'b000100,
    ST_RELEASE = 6'b001000,
    ST_DONE    = 6'b010000,
    ST_FAULT   = 6'b100000
  } disp_state_e;

  // Codes are ordered by ascending value, which the picker relies on.
  function automatic logic [MONEY_W-1:0] denom_value(input logic [DENOM_W-1:0] code);
    case (code)
      DENOM_1:  return 8'd1;
      DENOM_5:  return 8'd5;
      DENOM_10: return 8'd10;
      DENOM_20: return 8'd20;
      DENOM_50: return 8'd50;
      default:  return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_denom_pick.sv
// Combinational picker: largest denomination that is in stock and does not
// exceed the amount still owed.
module change_denom_pick
  import vm_pkg::*;
(
  input  logic [MONEY_W-1:0]    remaining,
  input  logic [NUM_DENOMS-1:0] stock_empty,
  output logic [DENOM_W-1:0]    code,
  output logic                  valid
);

  always_comb begin
    code  = '0;
    valid = 1'b0;
    // Ascending scan: the last eligible code seen is the largest one.
    for (int i = 0; i < NUM_DENOMS; i++) begin
      if (!stock_empty[i] && (denom_value(DENOM_W'(i)) <= remaining)) begin
        code  = DENOM_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change payout controller: greedily dispenses notes one at a time over a
// four-phase req/ack handshake, with stock-out and acknowledge-timeout faults.
module change_dispense_ctrl
  import vm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 5
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [MONEY_W-1:0]    change_amt,
  input  logic [NUM_DENOMS-1:0] stock_empty,
  input  logic                  dispense_ack,
  output logic                  dispense_req,
  output logic [DENOM_W-1:0]    dispense_denom,
  output logic [MONEY_W-1:0]    remaining,
  output logic [CNT_W-1:0]      note_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  fault
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  disp_state_e          state_q, state_d;
  logic [MONEY_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]     note_cnt_q, note_cnt_d;
  logic [DENOM_W-1:0]   denom_q, denom_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 fault_q, fault_d;
  logic                 done_q, done_d;
  logic [DENOM_W-1:0]   pick_code;
  logic                 pick_valid;

  change_denom_pick u_pick (
    .remaining   (remaining_q),
    .stock_empty (stock_empty),
    .code        (pick_code),
    .valid       (pick_valid)
  );

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path can infer a latch.
    state_d     = state_q;
    remaining_d = remaining_q;
    note_cnt_d  = note_cnt_q;
    denom_d     = denom_q;
    timer_d     = timer_q;
    fault_d     = fault_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = change_amt;
          note_cnt_d  = '0;
          fault_d     = 1'b0;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (remaining_q == '0) begin
          state_d = ST_DONE;
        end else if (pick_valid) begin
          denom_d = pick_code;
          timer_d = '0;
          state_d = ST_REQ;
        end else begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end
      end
      ST_REQ: begin
        if (dispense_ack) begin
          remaining_d = remaining_q - denom_value(denom_q);
          if (note_cnt_q != '1) note_cnt_d = note_cnt_q + CNT_W'(1);
          state_d = ST_RELEASE;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!dispense_ack) state_d = ST_SELECT;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      note_cnt_q  <= '0;
      denom_q     <= '0;
      timer_q     <= '0;
      fault_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      note_cnt_q  <= note_cnt_d;
      denom_q     <= denom_d;
      timer_q     <= timer_d;
      fault_q     <= fault_d;
      done_q      <= done_d;
    end
  end

  // Request comes straight off the one-hot state flop.
  assign dispense_req   = (state_q == ST_REQ);
  assign dispense_denom = denom_q;
  assign remaining      = remaining_q;
  assign note_cnt       = note_cnt_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Self-checking bench for change_dispense_ctrl: directed scenarios plus randomized
// payouts compared against a greedy change-making reference model.
module tb_change_dispense_ctrl;

  localparam int TO      = 1000;
  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int BUDGET  = 5000;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic             start;
  logic [7:0]       change_amt;
  logic [4:0]       stock_empty;
  logic             dispense_ack;
  logic             dispense_req;
  logic [2:0]       dispense_denom;
  logic [7:0]       remaining;
  logic [CNT_W-1:0] note_cnt;
  logic             busy;
  logic             done;
  logic             fault;

  int checks = 0;
  int errors = 0;

  int vals [5] = '{1, 5, 10, 20, 50};
  int exp_codes[$];
  int obs_codes[$];
  bit exp_fault;
  int exp_rem;

  change_dispense_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .start          (start),
    .change_amt     (change_amt),
    .stock_empty    (stock_empty),
    .dispense_ack   (dispense_ack),
    .dispense_req   (dispense_req),
    .dispense_denom (dispense_denom),
    .remaining      (remaining),
    .note_cnt       (note_cnt),
    .busy           (busy),
    .done           (done),
    .fault          (fault)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Greedy change-making: repeatedly take the largest in-stock note that fits.
  function automatic void model(input int amt, input int empty);
    int rem;
    int pick;
    exp_codes.delete();
    exp_fault = 1'b0;
    rem = amt;
    while (rem > 0) begin
      pick = -1;
      for (int i = 0; i < 5; i++)
        if (!empty[i] && vals[i] <= rem) pick = i;
      if (pick < 0) begin
        exp_fault = 1'b1;
        break;
      end
      exp_codes.push_back(pick);
      rem -= vals[pick];
    end
    exp_rem = rem;
  endfunction

  function automatic int first_diff();
    int n;
    n = (exp_codes.size() > obs_codes.size()) ? exp_codes.size() : obs_codes.size();
    for (int i = 0; i < n; i++) begin
      if (i >= exp_codes.size() || i >= obs_codes.size()) return i;
      if (exp_codes[i] != obs_codes[i]) return i;
    end
    return -1;
  endfunction

  function automatic int exp_cnt();
    return (exp_codes.size() > CNT_MAX) ? CNT_MAX : exp_codes.size();
  endfunction

  // Runs one payout acting as the actuator; checks each handshake on the fly.
  task automatic do_payout(input int amt, input int empty, input int ack_dly, input int hold,
                           input bit poke_start, output bit got_done, output bit got_fault);
    int rem_m;
    int notes;
    int code;
    bit poked;
    rem_m = amt;
    notes = 0;
    poked = 1'b0;
    got_done = 1'b0;
    got_fault = 1'b0;
    obs_codes.delete();
    @(negedge sys_clk);
    start = 1'b1; change_amt = amt[7:0]; stock_empty = empty[4:0];
    @(negedge sys_clk);
    start = 1'b0;
    for (int cyc = 0; cyc < BUDGET && !got_done && !got_fault; cyc++) begin
      if (done) got_done = 1'b1;
      else if (fault) got_fault = 1'b1;
      else if (dispense_req) begin
        code = int'(dispense_denom);
        obs_codes.push_back(code);
        if (poke_start && !poked) begin
          start = 1'b1; change_amt = 8'd200; stock_empty = 5'b0; poked = 1'b1;
        end
        for (int d = 0; d < ack_dly; d++) begin
          @(negedge sys_clk); start = 1'b0;
          checks++;
          if (dispense_req !== 1'b1 || int'(dispense_denom) != code) begin
            errors++;
            $display("FAIL req_hold: req=%b denom=%0d, required req=1 denom=%0d", dispense_req, dispense_denom, code);
          end
        end
        dispense_ack = 1'b1;
        @(negedge sys_clk); start = 1'b0;
        if (code < 5) rem_m -= vals[code];
        notes++;
        checks++;
        if (dispense_req !== 1'b0 || remaining !== rem_m[7:0] ||
            note_cnt !== CNT_W'((notes > CNT_MAX) ? CNT_MAX : notes)) begin
          errors++;
          $display("FAIL note_ack: req=%b rem=%0d cnt=%0d, required req=0 rem=%0d cnt=%0d",
                   dispense_req, remaining, note_cnt, rem_m, (notes > CNT_MAX) ? CNT_MAX : notes);
        end
        for (int h = 0; h < hold; h++) begin
          @(negedge sys_clk);
          checks++;
          if (dispense_req !== 1'b0 || remaining !== rem_m[7:0]) begin
            errors++;
            $display("FAIL ack_held: req=%b rem=%0d, required req=0 rem=%0d", dispense_req, remaining, rem_m);
          end
        end
        dispense_ack = 1'b0;
      end
      if (!got_done && !got_fault) @(negedge sys_clk);
    end
    if (!got_done && !got_fault) begin
      checks++; errors++;
      $display("FAIL payout_timeout: no done/fault within %0d cycles (amt=%0d)", BUDGET, amt);
    end
  endtask

  // Compares a finished payout with the model's prediction.
  task automatic check_outcome(input string name, input int amt, input int empty,
                               input bit got_done, input bit got_fault);
    int fd;
    model(amt, empty);
    fd = first_diff();
    checks++;
    if (fd >= 0) begin
      errors++;
      $display("FAIL %s codes: differ at note %0d (got %0d notes, required %0d)",
               name, fd, obs_codes.size(), exp_codes.size());
    end
    checks++;
    if (got_done !== !exp_fault || got_fault !== exp_fault || fault !== exp_fault) begin
      errors++;
      $display("FAIL %s result: done=%b fault=%b, required done=%b fault=%b",
               name, got_done, fault, !exp_fault, exp_fault);
    end
    checks++;
    if (remaining !== exp_rem[7:0] || note_cnt !== CNT_W'(exp_cnt())) begin
      errors++;
      $display("FAIL %s totals: rem=%0d cnt=%0d, required rem=%0d cnt=%0d",
               name, remaining, note_cnt, exp_rem, exp_cnt());
    end
    @(negedge sys_clk);
    if (got_done) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s done_pulse: done=%b busy=%b, required 0 0", name, done, busy);
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; start = 1'b0; change_amt = '0; stock_empty = '0; dispense_ack = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({dispense_req, dispense_denom, remaining, note_cnt, busy, done, fault} !== '0) begin
      errors++;
      $display("FAIL reset: req=%b denom=%0d rem=%0d cnt=%0d busy=%b done=%b fault=%b, required all 0",
               dispense_req, dispense_denom, remaining, note_cnt, busy, done, fault);
    end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_greedy_88();
    bit d, f;
    do_payout(88, 0, 2, 0, 1'b0, d, f);
    check_outcome("greedy_88", 88, 0, d, f);
  endtask

  task automatic test_zero();
    @(negedge sys_clk);
    start = 1'b1; change_amt = 8'd0; stock_empty = 5'b0;
    @(negedge sys_clk); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || dispense_req !== 1'b0) begin
      errors++;
      $display("FAIL zero_c1: busy=%b done=%b req=%b, required 1 0 0", busy, done, dispense_req);
    end
    @(negedge sys_clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || dispense_req !== 1'b0) begin
      errors++;
      $display("FAIL zero_c2: busy=%b done=%b req=%b, required 1 0 0", busy, done, dispense_req);
    end
    @(negedge sys_clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL zero_c3: busy=%b done=%b fault=%b, required 0 1 0", busy, done, fault);
    end
    @(negedge sys_clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_c4: done=%b, required 0", done);
    end
  endtask

  task automatic test_stock_20_empty();
    bit d, f;
    do_payout(30, 5'b01000, 1, 0, 1'b0, d, f);
    check_outcome("no_20s", 30, 5'b01000, d, f);
  endtask

  task automatic test_fault_no_stock();
    bit d, f;
    do_payout(3, 5'b00001, 1, 0, 1'b0, d, f);
    check_outcome("no_1s", 3, 5'b00001, d, f);
    checks++;
    if (fault !== 1'b1 || busy !== 1'b0 || dispense_req !== 1'b0) begin
      errors++;
      $display("FAIL fault_sticky: fault=%b busy=%b req=%b, required 1 0 0", fault, busy, dispense_req);
    end
    do_payout(3, 5'b00000, 0, 0, 1'b0, d, f);
    check_outcome("restock", 3, 0, d, f);
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    @(negedge sys_clk);
    start = 1'b1; change_amt = 8'd10; stock_empty = 5'b0; dispense_ack = 1'b0;
    @(negedge sys_clk); start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (dispense_req) seen = 1'b1;
      else @(negedge sys_clk);
    end
    n = 0;
    while (dispense_req === 1'b1 && n < TO + 20) begin
      n++;
      @(negedge sys_clk);
    end
    checks++;
    if (n != TO) begin
      errors++;
      $display("FAIL timeout_len: req high %0d cycles, required %0d", n, TO);
    end
    checks++;
    if (fault !== 1'b1 || dispense_req !== 1'b0 || remaining !== 8'd10 || note_cnt !== '0) begin
      errors++;
      $display("FAIL timeout_state: fault=%b req=%b rem=%0d cnt=%0d, required 1 0 10 0",
               fault, dispense_req, remaining, note_cnt);
    end
    @(negedge sys_clk);
    checks++;
    if (busy !== 1'b0 || fault !== 1'b1) begin
      errors++;
      $display("FAIL timeout_idle: busy=%b fault=%b, required 0 1", busy, fault);
    end
  endtask

  task automatic test_busy_start_and_ack_held();
    bit d, f;
    do_payout(37, 0, 1, 3, 1'b1, d, f);
    check_outcome("busy_start_ack_held", 37, 0, d, f);
  endtask

  task automatic test_saturate();
    bit d, f;
    do_payout(40, 5'b11110, 0, 0, 1'b0, d, f);
    check_outcome("saturate", 40, 5'b11110, d, f);
  endtask

  task automatic test_reset_mid_req();
    bit seen;
    @(negedge sys_clk);
    start = 1'b1; change_amt = 8'd50; stock_empty = 5'b0;
    @(negedge sys_clk); start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (dispense_req) seen = 1'b1;
      else @(negedge sys_clk);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({dispense_req, dispense_denom, remaining, note_cnt, busy, done, fault} !== '0) begin
      errors++;
      $display("FAIL reset_mid_req: req=%b denom=%0d rem=%0d cnt=%0d busy=%b done=%b fault=%b, required all 0",
               dispense_req, dispense_denom, remaining, note_cnt, busy, done, fault);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      checks++;
      if (dispense_req !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL after_reset: req=%b busy=%b, required 0 0", dispense_req, busy);
      end
    end
  endtask

  task automatic test_random();
    bit d, f;
    int amt, empty;
    for (int k = 0; k < 10; k++) begin
      amt   = int'($urandom_range(0, 255));
      empty = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 31));
      do_payout(amt, empty, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, d, f);
      check_outcome("random", amt, empty, d, f);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_greedy_88();
    test_stock_20_empty();
    test_fault_no_stock();
    test_timeout();
    test_busy_start_and_ack_held();
    test_saturate();
    test_reset_mid_req();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
